// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan selector: FSM state encoding
// and a width helper that never returns zero.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_IDLE   = 2'd2
    } state_t;

    // $clog2 collapses to 0 for n <= 1; a counter or index still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_rr_next_ch.sv
// Rotating priority encoder: finds the first set mask bit at or after
// (inclusive) or strictly after (exclusive) a start index, wrapping around.
module rr_next_ch #(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] mask,
    input  logic [SEL_W-1:0]    start,
    input  logic                inclusive,
    output logic [SEL_W-1:0]    idx,
    output logic                found
);

    int pos;

    // In exclusive mode the search ends on start itself, so a lone enabled
    // start channel is still found.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            pos = (int'(start) + k + (inclusive ? 0 : 1)) % CHANNELS;
            if (!found && mask[pos]) begin
                found = 1'b1;
                idx   = SEL_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel selector with manual select and round-robin scan
// through an enable mask, dwelling DWELL cycles per channel.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 8,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      hold,
    input  logic [CHANNELS-1:0]       ch_enable,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          cur_ch,
    output logic                      tick
);

    localparam int               CNT_W    = clog2_min1(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [SEL_W-1:0]   ch_nx;
    logic [SEL_W-1:0]   man_ch;
    logic               tick_nx;
    logic               blank_nx;
    logic [SEL_W-1:0]   rr_idx;
    logic               rr_found;
    logic [WIDTH-1:0]   chan [CHANNELS];

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            chan[i] = data_in[i*WIDTH +: WIDTH];
        end
    end

    // Out-of-range manual selects keep the current channel.
    assign man_ch = (32'(sel) < CHANNELS) ? sel : cur_ch;

    // Resuming from IDLE may land on cur_ch itself; a dwell advance must move past it.
    rr_next_ch #(.CHANNELS(CHANNELS)) u_rr (
        .mask      (ch_enable),
        .start     (cur_ch),
        .inclusive (state == ST_IDLE),
        .idx       (rr_idx),
        .found     (rr_found)
    );

    always_comb begin
        state_nx = state;
        ch_nx    = cur_ch;
        cnt_nx   = '0;
        tick_nx  = 1'b0;
        blank_nx = 1'b0;
        if (!mode) begin
            state_nx = ST_MANUAL;
            ch_nx    = man_ch;
        end else begin
            unique case (state)
                ST_MANUAL: state_nx = ST_SCAN;
                ST_SCAN: begin
                    if (ch_enable == '0) begin
                        state_nx = ST_IDLE;
                        blank_nx = 1'b1;
                    end else if (hold) begin
                        cnt_nx = cnt;
                    end else if (cnt == CNT_LAST) begin
                        ch_nx   = rr_idx;
                        tick_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (rr_found) begin
                        state_nx = ST_SCAN;
                        ch_nx    = rr_idx;
                        tick_nx  = 1'b1;
                    end else begin
                        blank_nx = 1'b1;
                    end
                end
                default: state_nx = ST_MANUAL;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_MANUAL;
            cnt      <= '0;
            cur_ch   <= '0;
            tick     <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            cur_ch   <= ch_nx;
            tick     <= tick_nx;
            data_out <= blank_nx ? '0 : chan[ch_nx];
        end
    end

endmodule
